// File: rtl/fetch_unit.sv
// Multi-issue instruction fetch unit: fetch PC, loadable instruction memory and a
// circular bundle queue presented to decode through a valid/ready handshake.
module fetch_unit #(
  parameter int unsigned IMEM_DEPTH  = 512,
  parameter int unsigned ISSUE_WIDTH = 2,
  parameter int unsigned BUF_DEPTH   = 4,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  localparam int unsigned AW = $clog2(IMEM_DEPTH),
  localparam int unsigned PW = $clog2(BUF_DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [31:0]              out_pc,
  output logic [32*ISSUE_WIDTH-1:0] out_inst,
  output logic [ISSUE_WIDTH-1:0]   out_slot_valid,
  input  logic                     imem_we,
  input  logic [AW-1:0]            imem_waddr,
  input  logic [31:0]              imem_wdata,
  output logic [31:0]              fetch_pc,
  output logic [CW-1:0]            queue_count
);

  localparam int unsigned BUNDLE_BYTES = 4 * ISSUE_WIDTH;

  logic [31:0]              mem     [IMEM_DEPTH];
  logic [31:0]              q_pc    [BUF_DEPTH];
  logic [32*ISSUE_WIDTH-1:0] q_inst [BUF_DEPTH];
  logic [ISSUE_WIDTH-1:0]   q_sv    [BUF_DEPTH];

  logic [PW-1:0]            head, tail;
  logic [CW-1:0]            count;
  logic [31:0]              fetch_base, slot_off;
  logic [AW-1:0]            widx;
  logic [32*ISSUE_WIDTH-1:0] fetch_inst;
  logic [ISSUE_WIDTH-1:0]   fetch_sv;
  logic                     full, deq, enq;
  logic                     unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];
  assign queue_count    = count;
  assign full           = (count == CW'(BUF_DEPTH));
  assign deq            = out_valid & out_ready;
  assign enq            = ~redirect_valid & (~full | deq);

  // Aligned bundle read straight from the array; slots below the PC offset are invalid.
  always_comb begin
    fetch_base = fetch_pc & ~32'(BUNDLE_BYTES - 1);
    slot_off   = (fetch_pc >> 2) & 32'(ISSUE_WIDTH - 1);
    fetch_inst = '0;
    fetch_sv   = '0;
    widx       = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      widx                 = AW'((fetch_base >> 2) + 32'(i));
      fetch_inst[32*i +: 32] = mem[widx];
      fetch_sv[i]          = (32'(i) >= slot_off);
    end
  end

  // Fetch PC and queue pointers; a redirect flushes and overrides any enqueue.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (enq) begin
        fetch_pc <= fetch_base + 32'(BUNDLE_BYTES);
        tail     <= tail + PW'(1);
      end
      if (deq) begin
        head <= head + PW'(1);
      end
      count <= count + CW'(enq) - CW'(deq);
    end
  end

  // Storage arrays carry no reset; validity lives in the count.
  always_ff @(posedge clock) begin
    if (enq) begin
      q_pc[tail]   <= fetch_base;
      q_inst[tail] <= fetch_inst;
      q_sv[tail]   <= fetch_sv;
    end
    if (imem_we) begin
      mem[imem_waddr] <= imem_wdata;
    end
  end

  always_comb begin
    out_valid      = (count != '0);
    out_pc         = '0;
    out_inst       = '0;
    out_slot_valid = '0;
    if (out_valid) begin
      out_pc         = q_pc[head];
      out_inst       = q_inst[head];
      out_slot_valid = q_sv[head];
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised and directed bench for fetch_unit against a bundle-queue reference model.
module tb_fetch_unit;
  localparam int unsigned IW    = 2;
  localparam int unsigned DEPTH = 512;
  localparam int unsigned BD    = 4;
  localparam int unsigned AW    = 9;
  localparam int unsigned CW    = 3;
  localparam int unsigned EW    = 1 + 32 + 32*IW + IW + CW + 32;

  logic            clock = 1'b0;
  logic            reset;
  logic            redirect_valid;
  logic [31:0]     redirect_pc;
  logic            out_ready;
  logic            out_valid;
  logic [31:0]     out_pc;
  logic [32*IW-1:0] out_inst;
  logic [IW-1:0]   out_slot_valid;
  logic            imem_we;
  logic [AW-1:0]   imem_waddr;
  logic [31:0]     imem_wdata;
  logic [31:0]     fetch_pc;
  logic [CW-1:0]   queue_count;

  int errors = 0;
  int checks = 0;

  fetch_unit #(.IMEM_DEPTH(DEPTH), .ISSUE_WIDTH(IW), .BUF_DEPTH(BD), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_ready(out_ready), .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
    .out_slot_valid(out_slot_valid), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .fetch_pc(fetch_pc), .queue_count(queue_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0]      pc;
    logic [32*IW-1:0] inst;
    logic [IW-1:0]    sv;
  } bundle_t;

  bundle_t     mq[$];
  logic [31:0] mmem [DEPTH];
  logic [31:0] mpc;

  function automatic bundle_t make_bundle(logic [31:0] pc);
    bundle_t b;
    logic [31:0] base;
    base = pc & ~32'(4*IW - 1);
    b.pc = base;
    b.inst = '0;
    b.sv = '0;
    for (int i = 0; i < IW; i++) begin
      b.inst[32*i +: 32] = mmem[int'(((base >> 2) + 32'(i)) % 32'(DEPTH))];
      b.sv[i] = (32'(i) >= ((pc >> 2) % 32'(IW)));
    end
    return b;
  endfunction

  // One rising edge of the reference: handshake, flush or refill, then the memory write.
  task automatic model_edge();
    bit deq;
    deq = (mq.size() > 0) && out_ready;
    if (redirect_valid) begin
      mq.delete();
      mpc = {redirect_pc[31:2], 2'b00};
    end else begin
      if (deq) void'(mq.pop_front());
      if (mq.size() < BD) begin
        mq.push_back(make_bundle(mpc));
        mpc = (mpc & ~32'(4*IW - 1)) + 32'(4*IW);
      end
    end
    if (imem_we) mmem[imem_waddr] = imem_wdata;
  endtask

  function automatic logic [EW-1:0] exp_v();
    bundle_t h;
    h = '0;
    if (mq.size() > 0) h = mq[0];
    return {mq.size() > 0, h.pc, h.inst, h.sv, CW'(mq.size()), mpc};
  endfunction

  function automatic logic [EW-1:0] obs_v();
    return {out_valid, out_pc, out_inst, out_slot_valid, queue_count, fetch_pc};
  endfunction

  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clock);
    #1;
    mq.delete();
    mpc = 32'h0;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
    #2 reset = 1'b0;
    #1;
    if (obs_v() !== '0) begin
      errors++; $display("FAIL reset_state: got %h want 0", obs_v());
    end
    checks++;
    for (int k = 0; k < int'(DEPTH); k++) begin
      imem_we = 1'b1; imem_waddr = AW'(k); imem_wdata = 32'(k);
      mmem[k] = 32'(k);
      @(posedge clock);
      #1;
    end
    imem_we = 1'b0;
    mq.delete(); mpc = 32'h0;
    reset = 1'b1; out_ready = 1'b1;
    step();
    if ({out_valid, out_pc, out_inst, out_slot_valid} !== {1'b1, 32'h0, 32'd1, 32'd0, 2'b11}) begin
      errors++; $display("FAIL first_bundle: got %b %h %h %b", out_valid, out_pc, out_inst, out_slot_valid);
    end
    checks++;
    step();
    if ({out_pc, out_inst} !== {32'h8, 32'd3, 32'd2}) begin
      errors++; $display("FAIL second_bundle: got %h %h want 8 00000003_00000002", out_pc, out_inst);
    end
    checks++;
    if (obs_v() !== exp_v()) begin
      errors++; $display("FAIL reset_model: got %h want %h", obs_v(), exp_v());
    end
    checks++;
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    repeat (6) begin
      step();
      if (obs_v() !== exp_v()) begin
        errors++; $display("FAIL fill_model: got %h want %h", obs_v(), exp_v());
      end
      checks++;
    end
    if ({queue_count, fetch_pc} !== {3'd4, 32'd32}) begin
      errors++; $display("FAIL full_hold: got count=%0d pc=%h want 4 00000020", queue_count, fetch_pc);
    end
    checks++;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (out_pc !== 32'(8*k)) begin
        errors++; $display("FAIL drain_seq: got %h want %h", out_pc, 32'(8*k));
      end
      checks++;
      step();
      if (obs_v() !== exp_v()) begin
        errors++; $display("FAIL drain_model: got %h want %h", obs_v(), exp_v());
      end
      checks++;
    end
  endtask

  task automatic test_redirect();
    out_ready = 1'b0;
    repeat (5) step();
    redirect_valid = 1'b1; redirect_pc = 32'h14;
    step();
    redirect_valid = 1'b0;
    if ({out_valid, queue_count, fetch_pc} !== {1'b0, 3'd0, 32'h14}) begin
      errors++; $display("FAIL redirect_flush: got %b %0d %h", out_valid, queue_count, fetch_pc);
    end
    checks++;
    step();
    if ({out_valid, out_pc, out_slot_valid, out_inst[63:32]} !== {1'b1, 32'h10, 2'b10, 32'd5}) begin
      errors++; $display("FAIL redirect_head: got %b %h %b %h", out_valid, out_pc, out_slot_valid, out_inst[63:32]);
    end
    checks++;
    out_ready = 1'b1;
    step();
    if ({out_pc, out_slot_valid} !== {32'h18, 2'b11}) begin
      errors++; $display("FAIL redirect_next: got %h %b want 00000018 11", out_pc, out_slot_valid);
    end
    checks++;
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 32'h7F8;
    step();
    redirect_valid = 1'b0; out_ready = 1'b0;
    step();
    if ({out_pc, out_inst} !== {32'h7F8, 32'd511, 32'd510}) begin
      errors++; $display("FAIL wrap_end: got %h %h", out_pc, out_inst);
    end
    checks++;
    out_ready = 1'b1;
    step();
    if ({out_pc, out_inst} !== {32'h800, 32'd1, 32'd0}) begin
      errors++; $display("FAIL wrap_start: got %h %h", out_pc, out_inst);
    end
    checks++;
    if (obs_v() !== exp_v()) begin
      errors++; $display("FAIL wrap_model: got %h want %h", obs_v(), exp_v());
    end
    checks++;
  endtask

  task automatic test_mem_write();
    out_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h8;
    step();
    redirect_valid = 1'b0;
    imem_we = 1'b1; imem_waddr = 9'd3; imem_wdata = 32'hDEAD_BEEF;
    step();
    imem_we = 1'b0;
    if ({out_pc, out_inst[63:32]} !== {32'h8, 32'd3}) begin
      errors++; $display("FAIL write_old_data: got %h %h want 00000008 00000003", out_pc, out_inst[63:32]);
    end
    checks++;
    redirect_valid = 1'b1; redirect_pc = 32'h8;
    step();
    redirect_valid = 1'b0;
    step();
    if (out_inst[63:32] !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL write_new_data: got %h want deadbeef", out_inst[63:32]);
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    redirect_pc = 32'h106;
    step();
    redirect_valid = 1'b0;
    if ({queue_count, fetch_pc} !== {3'd0, 32'h104}) begin
      errors++; $display("FAIL b2b_flush: got %0d %h want 0 00000104", queue_count, fetch_pc);
    end
    checks++;
    step();
    if ({out_pc, out_slot_valid, fetch_pc} !== {32'h100, 2'b10, 32'h108}) begin
      errors++; $display("FAIL b2b_last_wins: got %h %b %h", out_pc, out_slot_valid, fetch_pc);
    end
    checks++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      out_ready      = ($urandom % 4) != 0;
      redirect_valid = ($urandom % 10) == 0;
      redirect_pc    = $urandom;
      imem_we        = ($urandom % 4) == 0;
      imem_waddr     = AW'($urandom);
      imem_wdata     = $urandom;
      step();
      if (obs_v() !== exp_v()) begin
        errors++; $display("FAIL random_%0d: got %h want %h", n, obs_v(), exp_v());
      end
      checks++;
    end
    redirect_valid = 1'b0; imem_we = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    repeat (3) step();
    if (queue_count !== 3'd3) begin
      errors++; $display("FAIL mid_prefill: got %0d want 3", queue_count);
    end
    checks++;
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    #2 reset = 1'b0;
    #1;
    if (obs_v() !== '0) begin
      errors++; $display("FAIL mid_async_clear: got %h want 0", obs_v());
    end
    checks++;
    mq.delete(); mpc = 32'h0;
    redirect_valid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1; out_ready = 1'b1;
    step();
    if ({out_valid, out_pc, fetch_pc} !== {1'b1, 32'h0, 32'h8}) begin
      errors++; $display("FAIL mid_restart: got %b %h %h", out_valid, out_pc, fetch_pc);
    end
    checks++;
    if (obs_v() !== exp_v()) begin
      errors++; $display("FAIL mid_model: got %h want %h", obs_v(), exp_v());
    end
    checks++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_mem_write();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised multi-issue instruction fetch unit for the Cell SPU-lite pipeline. It holds the fetch PC and an internal instruction memory with a load port. Each cycle it reads an aligned bundle of ISSUE_WIDTH instructions into a small fetch queue, and presents bundles to decode with a valid/ready handshake. A branch redirect flushes the queue and restarts fetch at any word-aligned target; slots before the target are marked invalid.

## Interface
- IMEM_DEPTH, 512: instruction memory depth in 32-bit words; power of two.
- ISSUE_WIDTH, 2: instructions per bundle; power of two, 1..4.
- BUF_DEPTH, 4: fetch queue depth in bundles; power of two, at least 2.
- RESET_PC, 0: byte address fetched after reset; bundle-aligned.
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- redirect_valid  in  1  branch/redirect request, sampled at the rising edge.
- redirect_pc  in  32  redirect byte address; bits [1:0] are ignored.
- out_ready  in  1  decode accepts the head bundle.
- out_valid  out  1  head bundle is valid.
- out_pc  out  32  byte address of slot 0 of the head bundle (bundle-aligned).
- out_inst  out  32*ISSUE_WIDTH  head bundle; slot i is bits [32*i +: 32].
- out_slot_valid  out  ISSUE_WIDTH  per-slot valid of the head bundle.
- imem_we  in  1  instruction memory write enable.
- imem_waddr  in  log2(IMEM_DEPTH)  word address for the write.
- imem_wdata  in  32  write data.
- fetch_pc  out  32  current fetch byte address (debug/verification).
- queue_count  out  log2(BUF_DEPTH)+1  occupied queue entries.

## Operation
- PC is a byte address; word index = (fetch_pc >> 2) mod IMEM_DEPTH. Addresses wrap modulo IMEM_DEPTH*4.
- Bundle base = fetch_pc with the low log2(ISSUE_WIDTH)+2 bits cleared. Slot i reads word base/4 + i.
- Slot i is valid iff i >= (fetch_pc >> 2) mod ISSUE_WIDTH. This is nonzero only after an unaligned redirect.
- Enqueue when no redirect is sampled and (queue_count < BUF_DEPTH, or a dequeue happens in the same cycle).
  - On enqueue: fetch_pc <= base + 4*ISSUE_WIDTH (wraps at 32 bits).
  - Otherwise fetch_pc holds (stall by back-pressure).
- Dequeue when out_valid && out_ready. The head entry advances.
- Redirect: all queue entries are discarded at the edge and fetch_pc <= {redirect_pc[31:2], 2'b00}. No bundle is enqueued that cycle.
  - A handshake at the head in that same cycle still counts as accepted by decode.
- Memory reads are combinational from the array; writes are synchronous.
  - A write and a fetch of the same word in the same cycle: the fetch captures the old data, and the new data is visible from the next cycle.
  - Writes never flush the queue.
- out_* fields are driven from the queue head. When out_valid=0, out_inst, out_pc and out_slot_valid are 0.
- The queue is a circular buffer with head/tail pointers that wrap at BUF_DEPTH, plus a count. Full = (count == BUF_DEPTH); empty = (count == 0).

## Timing
- Reset asserted (asynchronous): fetch_pc=RESET_PC, queue_count=0, out_valid=0, out_pc=0, out_inst=0, out_slot_valid=0. Memory contents are not cleared.
- First edge after reset release: bundle at RESET_PC is enqueued. out_valid=1 after that edge (1-cycle fetch latency).
- Steady state with out_ready=1: one bundle per cycle, queue_count stays at 1, out_pc increments by 4*ISSUE_WIDTH.
- out_ready=0: the queue fills at one entry per cycle, then fetch_pc freezes at full.
  - When out_ready returns to 1, dequeue and enqueue happen in the same cycle and throughput does not drop.
- Redirect sampled at edge N:
  - After N: queue_count=0, out_valid=0, fetch_pc=target.
  - After N+1: target bundle is at the head, out_valid=1.
  - Redirect-to-valid latency is 2 edges.
- Back-to-back redirects: the last one sampled wins, and each one flushes.
- Reset asserted mid-operation aborts everything immediately. Pending queue contents are lost.

## Test plan
- Reset release, ISSUE_WIDTH=2, memory word k = k:
  - after edge 1: out_valid=1, out_pc=0, out_inst={1,0} (slot1, slot0), out_slot_valid=2'b11;
  - with out_ready=1, next out_pc=8, out_inst={3,2}.
- out_ready=0 for 6 cycles after reset:
  - queue_count saturates at 4 and fetch_pc holds at 32;
  - after release, out_pc sequence is 0, 8, 16, 24, 32, ... with no gaps or duplicates.
- Redirect to 0x0000_0014 while the queue is full:
  - next cycle out_valid=0 and queue_count=0;
  - following cycle out_pc=0x10, out_slot_valid=2'b10, slot1=word 5;
  - next bundle out_pc=0x18, out_slot_valid=2'b11.
- Wrap-around with IMEM_DEPTH=512:
  - redirect to 0x7F8: bundle holds words 510 and 511;
  - next out_pc=0x800 with data from words 0 and 1.
- Write word 3 := 0xDEAD_BEEF in the same cycle that fetch reads bundle 2-3: that bundle carries the old data. A later redirect to 8 returns 0xDEAD_BEEF in slot 1.
- Assert reset with 3 entries queued and a redirect pending:
  - outputs clear asynchronously before the next edge;
  - after release, fetch restarts at RESET_PC.
